mdu: RTL and testbench

MDU -- requirements
Module: mdu

---
 rtl/mdu_pkg.sv | 39 +++
 rtl/mdu_alu.sv | 49 ++++
 rtl/mdu.sv | 87 ++++++++
 tb/tb_mdu.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared MDU definitions: op codes, FSM state encoding and op-class helpers.
// Build option: MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  // Ops that occupy the unit for MULT_CYCLES.
  function automatic logic is_mul_op(input logic [3:0] op);
`ifdef MDU_MADD_EN
    return (op == OP_MULT) || (op == OP_MULTU) ||
           (op == OP_MADD) || (op == OP_MADDU) ||
           (op == OP_MSUB) || (op == OP_MSUBU);
`else
    return (op == OP_MULT) || (op == OP_MULTU);
`endif
  endfunction

  function automatic logic is_div_op(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_alu.sv
// Combinational MDU arithmetic: products, divide, optional accumulate (MDU_MADD_EN).
// Result is {hi,lo}; ops with no arithmetic effect (incl. divide by zero) pass {hi,lo} through.
module mdu_alu
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] result
);

  logic [63:0] w_sprod;
  logic [63:0] w_uprod;
  logic        w_sdiv;
  logic [31:0] w_na, w_nb, w_q, w_r, w_qo, w_ro;

  assign w_sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign w_uprod = {32'b0, a} * {32'b0, b};

  // Signed divide via magnitudes: truncates toward zero, remainder follows dividend.
  // 0x80000000 / -1 falls out naturally as quotient 0x80000000, remainder 0.
  assign w_sdiv = (op == OP_DIV);
  assign w_na   = (w_sdiv && a[31]) ? -a : a;
  assign w_nb   = (w_sdiv && b[31]) ? -b : b;
  assign w_q    = (w_nb == 32'd0) ? 32'd0 : w_na / w_nb;
  assign w_r    = (w_nb == 32'd0) ? 32'd0 : w_na % w_nb;
  assign w_qo   = (w_sdiv && (a[31] ^ b[31])) ? -w_q : w_q;
  assign w_ro   = (w_sdiv && a[31]) ? -w_r : w_r;

  always_comb begin
    result = {hi, lo};
    case (mdu_op_e'(op))
      OP_MULT:  result = w_sprod;
      OP_MULTU: result = w_uprod;
      OP_DIV,
      OP_DIVU:  if (b != 32'd0) result = {w_ro, w_qo};
`ifdef MDU_MADD_EN
      OP_MADD:  result = {hi, lo} + w_sprod;
      OP_MADDU: result = {hi, lo} + w_uprod;
      OP_MSUB:  result = {hi, lo} - w_sprod;
      OP_MSUBU: result = {hi, lo} - w_uprod;
`endif
      default:  result = {hi, lo};
    endcase
  end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit: IDLE/BUSY FSM, busy counter, shadow result and HI/LO registers.
// Build option: MDU_MADD_EN (accumulate ops 7-10). Cycle parameters must be >= 1.
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  mdu_state_e       r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_hi, r_lo, r_shi, r_slo;
  logic [63:0]      w_res;
  logic             w_idle, w_go, w_done;

  mdu_alu u_alu (
    .op     (op),
    .a      (a),
    .b      (b),
    .hi     (r_hi),
    .lo     (r_lo),
    .result (w_res)
  );

  assign w_idle = (r_state == ST_IDLE);
  assign w_go   = w_idle && start && (is_mul_op(op) || is_div_op(op));
  assign w_done = (r_state == ST_BUSY) && (r_cnt == CNT_W'(1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_go)   w_next = ST_BUSY;
      ST_BUSY: if (w_done) w_next = ST_IDLE;
      default:             w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Result is captured at acceptance; HI/LO only move on completion or an idle MTHI/MTLO.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_shi <= '0;
      r_slo <= '0;
    end else begin
      if (w_go) begin
        r_cnt          <= is_div_op(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        {r_shi, r_slo} <= w_res;
      end else if (r_state == ST_BUSY) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end

      if (w_done) begin
        r_hi <= r_shi;
        r_lo <= r_slo;
      end else if (w_idle && start && (op == OP_MTHI)) begin
        r_hi <= a;
      end else if (w_idle && start && (op == OP_MTLO)) begin
        r_lo <= a;
      end
    end
  end

  assign busy = (r_state == ST_BUSY);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: arithmetic reference model compared every cycle,
// plus directed vectors with hand-computed literals.
module tb_mdu;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  // Reference model: a countdown of remaining busy cycles and the pending result.
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  int          m_left = 0;

  always @(posedge clk) begin
    longint sa, sb, ua, ub, acc, q, r;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    acc = longint'({m_hi, m_lo});
    if (reset) begin
      m_hi = '0; m_lo = '0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin m_hi = p_hi; m_lo = p_lo; end
    end else if (start) begin
      case (op)
        4'd1: begin {p_hi, p_lo} = sa * sb; m_left = MC; end
        4'd2: begin {p_hi, p_lo} = ua * ub; m_left = MC; end
        4'd3, 4'd4: begin
          {p_hi, p_lo} = {m_hi, m_lo};
          if (b != 0) begin
            q = (op == 4'd3) ? sa / sb : ua / ub;
            r = (op == 4'd3) ? sa % sb : ua % ub;
            p_lo = q[31:0]; p_hi = r[31:0];
          end
          m_left = DC;
        end
        4'd5: m_hi = a;
        4'd6: m_lo = a;
`ifdef MDU_MADD_EN
        4'd7:  begin {p_hi, p_lo} = acc + sa * sb; m_left = MC; end
        4'd8:  begin {p_hi, p_lo} = acc + ua * ub; m_left = MC; end
        4'd9:  begin {p_hi, p_lo} = acc - sa * sb; m_left = MC; end
        4'd10: begin {p_hi, p_lo} = acc - ua * ub; m_left = MC; end
`endif
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if (busy !== (m_left > 0) || hi !== m_hi || lo !== m_lo) begin
        n_bad++;
        $display("FAIL model t=%0t: got busy=%b hi=%h lo=%h want busy=%b hi=%h lo=%h",
                 $time, busy, hi, lo, (m_left > 0), m_hi, m_lo);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One-cycle start pulse; returns at the negedge after the accepting edge.
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
  endtask

  task automatic expect_busy_run(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      check(name, {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (busy === 1'b1 && k < 50) begin @(negedge clk); k++; end
    check({name, "_timeout"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    chk_en = 1'b1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);

    // -2 * 3
    issue(4'd1, 32'hFFFFFFFE, 32'd3);
    expect_busy_run("mult_busy", MC);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFFA);

    // -7 / 2
    issue(4'd3, 32'hFFFFFFF9, 32'd2);
    expect_busy_run("div_busy", DC);
    check("div_lo", lo, 32'hFFFFFFFD);
    check("div_hi", hi, 32'hFFFFFFFF);

    issue(4'd4, 32'd7, 32'd2);
    wait_idle("divu");
    check("divu_lo", lo, 32'd3);
    check("divu_hi", hi, 32'd1);

    // 7 / -2 -> q=-3, r=1
    issue(4'd3, 32'd7, 32'hFFFFFFFE);
    wait_idle("divneg");
    check("divneg_lo", lo, 32'hFFFFFFFD);
    check("divneg_hi", hi, 32'd1);

    // MTHI then divide by zero
    do_reset();
    issue(4'd5, 32'h12345678, 32'd0);
    check("mthi_hi", hi, 32'h12345678);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    issue(4'd4, 32'd99, 32'd0);
    expect_busy_run("div0_busy", DC);
    check("div0_hi", hi, 32'h12345678);
    check("div0_lo", lo, 32'd0);

    // MULTU max*max with MTLO while busy
    issue(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue(4'd6, 32'hDEADBEEF, 32'd0);
    wait_idle("multu");
    check("multu_hi", hi, 32'hFFFFFFFE);
    check("multu_lo", lo, 32'h00000001);

    // Overflow divide
    issue(4'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_idle("divovf");
    check("divovf_lo", lo, 32'h80000000);
    check("divovf_hi", hi, 32'd0);

    // Negative * negative
    issue(4'd1, 32'hFFFFFFFF, 32'h80000000);
    wait_idle("multnn");
    check("multnn_hi", hi, 32'd0);
    check("multnn_lo", lo, 32'h80000000);

    // NOP codes change nothing
    for (int c = 11; c < 16; c++) issue(4'(c), 32'hA5A5A5A5, 32'h3);
    issue(4'd0, 32'h1, 32'h1);
    check("nop_hi", hi, 32'd0);
    check("nop_lo", lo, 32'h80000000);
    check("nop_busy", {31'd0, busy}, 32'd0);

    // Reset aborts a DIV on its third busy cycle
    issue(4'd5, 32'h11111111, 32'd0);
    issue(4'd3, 32'd100, 32'd7);
    @(negedge clk);
    @(negedge clk);
    do_reset();
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    repeat (DC + 2) @(negedge clk);
    check("abort_hi_late", hi, 32'd0);
    check("abort_lo_late", lo, 32'd0);

    // MADDU carry across lo
    issue(4'd6, 32'hFFFFFFFF, 32'd0);
    issue(4'd8, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
    expect_busy_run("maddu_busy", MC);
    check("maddu_hi", hi, 32'd1);
    check("maddu_lo", lo, 32'd0);
    issue(4'd9, 32'hFFFFFFFF, 32'd1);
    wait_idle("msub");
    check("msub_hi", hi, 32'd1);
    check("msub_lo", lo, 32'd1);
`else
    check("maddu_busy", {31'd0, busy}, 32'd0);
    repeat (MC + 1) @(negedge clk);
    check("maddu_hi", hi, 32'd0);
    check("maddu_lo", lo, 32'hFFFFFFFF);
`endif

    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
